// File: rtl/cp0_timer.sv
// MIPS coprocessor-0: SR, Cause, EPC, PRId, Count/Compare timer and exception/interrupt entry
// arbitration for the M-stage instruction, with a configurable number of hardware interrupt lines.
module cp0_timer #(
  parameter int unsigned NUM_HWINT      = 5,
  parameter logic [31:0] PRID           = 32'h12345678,
  parameter int unsigned COUNT_DIV_LOG2 = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_HWINT-1:0] hwint,
  input  logic                 we,
  input  logic [4:0]           wr_addr,
  input  logic [31:0]          wr_data,
  input  logic [4:0]           rd_addr,
  output logic [31:0]          rd_data,
  input  logic                 exc_req,
  input  logic [4:0]           exc_code,
  input  logic                 exc_bd,
  input  logic [31:0]          exc_pc,
  input  logic                 eret,
  output logic                 int_req,
  output logic                 take,
  output logic [31:0]          epc,
  output logic                 exl
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_SR      = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_PRID    = 5'd15;

  logic [5:0]           im_q, im_d;
  logic                 ie_q, ie_d;
  logic                 exl_q, exl_d;
  logic                 bd_q, bd_d;
  logic                 ti_q, ti_d;
  logic [4:0]           exccode_q, exccode_d;
  logic [31:0]          epc_q, epc_d;
  logic [31:0]          count_q, count_d;
  logic [31:0]          compare_q, compare_d;
  logic [NUM_HWINT-1:0] ip_q;

  logic                 tick_s;
  logic                 wr_ok_s;
  logic                 count_wr_s;
  logic                 compare_wr_s;
  logic [NUM_HWINT:0]   pending_s;
  logic [5:0]           ip_field_s;

  generate
    if (COUNT_DIV_LOG2 == 0) begin : g_no_presc
      assign tick_s = 1'b1;
    end else begin : g_presc
      logic [COUNT_DIV_LOG2-1:0] presc_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) presc_q <= '0;
        else       presc_q <= presc_q + COUNT_DIV_LOG2'(1);
      end
      // Count advances on the cycle the prescaler sits at its terminal value.
      assign tick_s = &presc_q;
    end
  endgenerate

  // TI occupies the IP7 slot above the hardware lines and is masked by IM[15].
  assign pending_s    = {ti_q & im_q[5], ip_q & im_q[NUM_HWINT-1:0]};
  assign int_req      = ie_q & ~exl_q & (|pending_s);
  assign take         = (int_req | exc_req) & ~reset;
  assign wr_ok_s      = we & ~take;
  assign count_wr_s   = wr_ok_s & (wr_addr == ADDR_COUNT);
  assign compare_wr_s = wr_ok_s & (wr_addr == ADDR_COMPARE);
  assign ip_field_s   = 6'(ip_q);
  assign epc          = epc_q;
  assign exl          = exl_q;

  always_comb begin
    im_d      = im_q;
    ie_d      = ie_q;
    exl_d     = exl_q;
    bd_d      = bd_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    compare_d = compare_q;
    if (tick_s) count_d = count_q + 32'd1;
    else        count_d = count_q;

    if (take) begin
      exl_d     = 1'b1;
      exccode_d = int_req ? 5'd0 : exc_code;
      // A nested exception keeps the original return point.
      if (!exl_q) begin
        bd_d  = exc_bd;
        epc_d = exc_bd ? (exc_pc - 32'd4) : exc_pc;
      end else begin
        bd_d  = bd_q;
      end
    end else begin
      if (eret) exl_d = 1'b0;
      else      exl_d = exl_q;
      if (we) begin
        case (wr_addr)
          ADDR_SR: begin
            im_d  = wr_data[15:10];
            exl_d = wr_data[1];
            ie_d  = wr_data[0];
          end
          ADDR_EPC:     epc_d     = {wr_data[31:2], 2'b00};
          ADDR_COUNT:   count_d   = wr_data;
          ADDR_COMPARE: compare_d = wr_data;
          default:      ;
        endcase
      end else begin
        im_d = im_q;
      end
    end

    if (compare_wr_s)                                       ti_d = 1'b0;
    else if ((tick_s | count_wr_s) && count_d == compare_q) ti_d = 1'b1;
    else                                                    ti_d = ti_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q      <= 6'd0;
      ie_q      <= 1'b0;
      exl_q     <= 1'b0;
      bd_q      <= 1'b0;
      ti_q      <= 1'b0;
      exccode_q <= 5'd0;
      epc_q     <= 32'd0;
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      ip_q      <= '0;
    end else begin
      im_q      <= im_d;
      ie_q      <= ie_d;
      exl_q     <= exl_d;
      bd_q      <= bd_d;
      ti_q      <= ti_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ip_q      <= hwint;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (rd_addr)
      ADDR_COUNT:   rd_data = count_q;
      ADDR_COMPARE: rd_data = compare_q;
      ADDR_SR:      rd_data = {16'd0, im_q, 8'd0, exl_q, ie_q};
      ADDR_CAUSE:   rd_data = {bd_q, ti_q, 14'd0, ip_field_s, 3'd0, exccode_q, 2'd0};
      ADDR_EPC:     rd_data = epc_q;
      ADDR_PRID:    rd_data = PRID;
      default:      rd_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_timer.sv
// Bench for cp0_timer: table of per-cycle vectors checked through a scoreboard queue,
// plus hand-written timer, wrap, prescaler and asynchronous-reset sequences.
module tb_cp0_timer;

  localparam logic [31:0] PRID_V = 32'h12345678;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  hwint = 5'd0;
  logic        we = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [31:0] wr_data = 32'd0;
  logic [4:0]  rd_addr = 5'd0;
  logic        exc_req = 1'b0;
  logic [4:0]  exc_code = 5'd0;
  logic        exc_bd = 1'b0;
  logic [31:0] exc_pc = 32'd0;
  logic        eret = 1'b0;
  logic [31:0] rd_data, epc, rd_data2, epc2;
  logic        int_req, take, exl, int_req2, take2, exl2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cp0_timer #(.NUM_HWINT(5), .PRID(PRID_V), .COUNT_DIV_LOG2(0)) u_dut (
    .clk(clk), .reset(reset), .hwint(hwint), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .exc_req(exc_req), .exc_code(exc_code),
    .exc_bd(exc_bd), .exc_pc(exc_pc), .eret(eret), .int_req(int_req), .take(take),
    .epc(epc), .exl(exl));

  cp0_timer #(.NUM_HWINT(5), .PRID(PRID_V), .COUNT_DIV_LOG2(1)) u_dut_div (
    .clk(clk), .reset(reset), .hwint(hwint), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data2), .exc_req(exc_req), .exc_code(exc_code),
    .exc_bd(exc_bd), .exc_pc(exc_pc), .eret(eret), .int_req(int_req2), .take(take2),
    .epc(epc2), .exl(exl2));

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  hw;
    logic        er;
    logic [4:0]  ec;
    logic        bd;
    logic [31:0] pc;
    logic        et;
    logic [31:0] x_rd;
    logic        x_int;
    logic        x_take;
    logic [31:0] x_epc;
    logic        x_exl;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        intr;
    logic        tk;
    logic [31:0] ep;
    logic        ex;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];

  function automatic vec_t mk(string n, logic we_, logic [4:0] wa_, logic [31:0] wd_,
                              logic [4:0] ra_, logic [4:0] hw_, logic er_, logic [4:0] ec_,
                              logic bd_, logic [31:0] pc_, logic et_, logic [31:0] xrd,
                              logic xi, logic xt, logic [31:0] xe, logic xx);
    vec_t v;
    v.name = n;   v.we = we_;   v.wa = wa_;   v.wd = wd_;   v.ra = ra_;   v.hw = hw_;
    v.er = er_;   v.ec = ec_;   v.bd = bd_;   v.pc = pc_;   v.et = et_;
    v.x_rd = xrd; v.x_int = xi; v.x_take = xt; v.x_epc = xe; v.x_exl = xx;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp_v);
    end
  endtask

  task automatic chk1(input string n, input logic act, input logic exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", n, act, exp_v);
    end
  endtask

  task automatic apply(input vec_t v);
    we = v.we; wr_addr = v.wa; wr_data = v.wd; rd_addr = v.ra; hwint = v.hw;
    exc_req = v.er; exc_code = v.ec; exc_bd = v.bd; exc_pc = v.pc; eret = v.et;
  endtask

  // Drive one table vector, queue its expectation, then compare once outputs settle.
  task automatic run_vec(input vec_t v);
    exp_t e;
    @(negedge clk);
    apply(v);
    sb_q.push_back('{v.name, v.x_rd, v.x_int, v.x_take, v.x_epc, v.x_exl});
    #2;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty got 0 expected 1", v.name);
    end else begin
      e = sb_q.pop_front();
      chk({e.name, "_rd"}, rd_data, e.rd);
      chk1({e.name, "_int"}, int_req, e.intr);
      chk1({e.name, "_take"}, take, e.tk);
      chk({e.name, "_epc"}, epc, e.ep);
      chk1({e.name, "_exl"}, exl, e.ex);
    end
  endtask

  task automatic cyc(input logic we_, input logic [4:0] wa_, input logic [31:0] wd_,
                     input logic [4:0] ra_, input logic et_);
    @(negedge clk);
    apply(mk("", we_, wa_, wd_, ra_, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, et_,
             32'd0, 1'b0, 1'b0, 32'd0, 1'b0));
    #2;
  endtask

  initial begin
    // name, we, wa, wd, ra, hw, er, ec, bd, pc, eret | rd, int, take, epc, exl
    tbl.push_back(mk("sr_wr",    1'b1, 5'd12, 32'h0000FC01, 5'd12, 5'd0, 1'b0, 5'd0,  1'b0, 32'h0,    1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    1'b0));
    tbl.push_back(mk("hw_raise", 1'b0, 5'd0,  32'h0,        5'd12, 5'd1, 1'b0, 5'd0,  1'b0, 32'h0,    1'b0, 32'h0000FC01, 1'b0, 1'b0, 32'h0,    1'b0));
    tbl.push_back(mk("int_take", 1'b0, 5'd0,  32'h0,        5'd13, 5'd1, 1'b0, 5'd0,  1'b0, 32'h3008, 1'b0, 32'h00000400, 1'b1, 1'b1, 32'h0,    1'b0));
    tbl.push_back(mk("int_done", 1'b0, 5'd0,  32'h0,        5'd13, 5'd0, 1'b0, 5'd0,  1'b0, 32'h0,    1'b0, 32'h00000400, 1'b0, 1'b0, 32'h3008, 1'b1));
    tbl.push_back(mk("eret1",    1'b0, 5'd0,  32'h0,        5'd13, 5'd0, 1'b0, 5'd0,  1'b0, 32'h0,    1'b1, 32'h0,        1'b0, 1'b0, 32'h3008, 1'b1));
    tbl.push_back(mk("exc_bd",   1'b0, 5'd0,  32'h0,        5'd14, 5'd0, 1'b1, 5'd4,  1'b1, 32'h3010, 1'b0, 32'h3008,     1'b0, 1'b1, 32'h3008, 1'b0));
    tbl.push_back(mk("cause_bd", 1'b0, 5'd0,  32'h0,        5'd13, 5'd0, 1'b0, 5'd0,  1'b0, 32'h0,    1'b0, 32'h80000010, 1'b0, 1'b0, 32'h300C, 1'b1));
    tbl.push_back(mk("exc_nest", 1'b0, 5'd0,  32'h0,        5'd14, 5'd0, 1'b1, 5'd12, 1'b0, 32'h5000, 1'b0, 32'h300C,     1'b0, 1'b1, 32'h300C, 1'b1));
    tbl.push_back(mk("cause_nst",1'b0, 5'd0,  32'h0,        5'd13, 5'd0, 1'b0, 5'd0,  1'b0, 32'h0,    1'b0, 32'h80000030, 1'b0, 1'b0, 32'h300C, 1'b1));
    tbl.push_back(mk("sr_eret",  1'b1, 5'd12, 32'h0000FC03, 5'd12, 5'd0, 1'b0, 5'd0,  1'b0, 32'h0,    1'b1, 32'h0000FC03, 1'b0, 1'b0, 32'h300C, 1'b1));
    tbl.push_back(mk("eret2",    1'b0, 5'd0,  32'h0,        5'd12, 5'd0, 1'b0, 5'd0,  1'b0, 32'h0,    1'b1, 32'h0000FC03, 1'b0, 1'b0, 32'h300C, 1'b1));
    tbl.push_back(mk("cause_wr", 1'b1, 5'd13, 32'hFFFFFFFF, 5'd12, 5'd0, 1'b0, 5'd0,  1'b0, 32'h0,    1'b0, 32'h0000FC01, 1'b0, 1'b0, 32'h300C, 1'b0));
    tbl.push_back(mk("prid_wr",  1'b1, 5'd15, 32'h0,        5'd13, 5'd0, 1'b0, 5'd0,  1'b0, 32'h0,    1'b0, 32'h80000030, 1'b0, 1'b0, 32'h300C, 1'b0));
    tbl.push_back(mk("unmap_wr", 1'b1, 5'd20, 32'h0000DEAD, 5'd15, 5'd0, 1'b0, 5'd0,  1'b0, 32'h0,    1'b0, PRID_V,       1'b0, 1'b0, 32'h300C, 1'b0));
    tbl.push_back(mk("unmap_rd", 1'b0, 5'd0,  32'h0,        5'd20, 5'd0, 1'b0, 5'd0,  1'b0, 32'h0,    1'b0, 32'h0,        1'b0, 1'b0, 32'h300C, 1'b0));
    tbl.push_back(mk("hw_again", 1'b0, 5'd0,  32'h0,        5'd12, 5'd1, 1'b0, 5'd0,  1'b0, 32'h0,    1'b0, 32'h0000FC01, 1'b0, 1'b0, 32'h300C, 1'b0));
    tbl.push_back(mk("prio_col", 1'b1, 5'd14, 32'h00001234, 5'd14, 5'd1, 1'b1, 5'd10, 1'b1, 32'h4000, 1'b0, 32'h300C,     1'b1, 1'b1, 32'h300C, 1'b0));
    tbl.push_back(mk("prio_cau", 1'b0, 5'd0,  32'h0,        5'd13, 5'd0, 1'b0, 5'd0,  1'b0, 32'h0,    1'b0, 32'h80000400, 1'b0, 1'b0, 32'h3FFC, 1'b1));
    tbl.push_back(mk("epc_wr",   1'b1, 5'd14, 32'h0000ABCF, 5'd14, 5'd0, 1'b0, 5'd0,  1'b0, 32'h0,    1'b0, 32'h3FFC,     1'b0, 1'b0, 32'h3FFC, 1'b1));
    tbl.push_back(mk("epc_rd",   1'b0, 5'd0,  32'h0,        5'd14, 5'd0, 1'b0, 5'd0,  1'b0, 32'h0,    1'b0, 32'hABCC,     1'b0, 1'b0, 32'hABCC, 1'b1));
    tbl.push_back(mk("im_clr",   1'b1, 5'd12, 32'h00000001, 5'd12, 5'd0, 1'b0, 5'd0,  1'b0, 32'h0,    1'b0, 32'h0000FC03, 1'b0, 1'b0, 32'hABCC, 1'b1));
    tbl.push_back(mk("mask_hw",  1'b0, 5'd0,  32'h0,        5'd12, 5'd1, 1'b0, 5'd0,  1'b0, 32'h0,    1'b0, 32'h00000001, 1'b0, 1'b0, 32'hABCC, 1'b0));
    tbl.push_back(mk("mask_chk", 1'b0, 5'd0,  32'h0,        5'd13, 5'd1, 1'b0, 5'd0,  1'b0, 32'h0,    1'b0, 32'h80000400, 1'b0, 1'b0, 32'hABCC, 1'b0));
    tbl.push_back(mk("im10_wr",  1'b1, 5'd12, 32'h00000401, 5'd12, 5'd0, 1'b0, 5'd0,  1'b0, 32'h0,    1'b0, 32'h00000001, 1'b0, 1'b0, 32'hABCC, 1'b0));
    tbl.push_back(mk("im10_rd",  1'b0, 5'd0,  32'h0,        5'd12, 5'd0, 1'b0, 5'd0,  1'b0, 32'h0,    1'b0, 32'h00000401, 1'b0, 1'b0, 32'hABCC, 1'b0));

    // Reset state, with a pending exception request that must not produce take.
    exc_req = 1'b1;
    rd_addr = 5'd15;
    @(posedge clk);
    #2;
    chk("rst_prid", rd_data, PRID_V);
    chk1("rst_take", take, 1'b0);
    chk1("rst_int", int_req, 1'b0);
    chk1("rst_exl", exl, 1'b0);
    chk("rst_epc", epc, 32'd0);
    chk1("rst_take2", take2, 1'b0);
    chk1("rst_int2", int_req2, 1'b0);
    chk1("rst_exl2", exl2, 1'b0);
    chk("rst_epc2", epc2, 32'd0);
    rd_addr = 5'd9;
    #1;
    chk("rst_count", rd_data, 32'd0);
    @(negedge clk);
    exc_req = 1'b0;
    reset = 1'b0;

    // Count every cycle on the undivided timer, every other cycle with a 1-bit prescaler.
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #2;
      chk("cnt_div0", rd_data, 32'(k));
      chk("cnt_div1", rd_data2, 32'(k / 2));
    end

    foreach (tbl[i]) run_vec(tbl[i]);

    // Timer match with Compare=10.
    cyc(1'b1, 5'd11, 32'd10, 5'd0, 1'b0);
    cyc(1'b1, 5'd9, 32'd0, 5'd0, 1'b0);
    cyc(1'b1, 5'd12, 32'h00008001, 5'd9, 1'b0);
    chk("tmr_cnt0", rd_data, 32'd0);
    for (int k = 1; k <= 9; k++) begin
      cyc(1'b0, 5'd0, 32'd0, 5'd9, 1'b0);
      chk("tmr_cnt", rd_data, 32'(k));
      chk1("tmr_noint", int_req, 1'b0);
    end
    cyc(1'b0, 5'd0, 32'd0, 5'd9, 1'b0);
    chk("tmr_cnt10", rd_data, 32'd10);
    chk1("tmr_int", int_req, 1'b1);
    chk1("tmr_take", take, 1'b1);
    cyc(1'b1, 5'd11, 32'd100, 5'd13, 1'b0);
    chk("tmr_ti_set", rd_data, 32'h40000000);
    chk1("tmr_exl", exl, 1'b1);
    cyc(1'b0, 5'd0, 32'd0, 5'd13, 1'b1);
    chk("tmr_ti_clr", rd_data, 32'h00000000);
    cyc(1'b0, 5'd0, 32'd0, 5'd13, 1'b0);
    chk1("tmr_int_off", int_req, 1'b0);
    chk1("tmr_exl_off", exl, 1'b0);

    // Count wrap onto Compare=0.
    cyc(1'b1, 5'd11, 32'd0, 5'd9, 1'b0);
    cyc(1'b1, 5'd9, 32'hFFFFFFFF, 5'd9, 1'b0);
    cyc(1'b0, 5'd0, 32'd0, 5'd9, 1'b0);
    chk("wrap_max", rd_data, 32'hFFFFFFFF);
    chk1("wrap_noint", int_req, 1'b0);
    cyc(1'b0, 5'd0, 32'd0, 5'd9, 1'b0);
    chk("wrap_zero", rd_data, 32'd0);
    chk1("wrap_int", int_req, 1'b1);
    cyc(1'b0, 5'd0, 32'd0, 5'd13, 1'b0);
    chk("wrap_ti", rd_data, 32'h40000000);
    chk1("wrap_exl", exl, 1'b1);

    // Asynchronous reset between edges with Count=500 and an interrupt pending.
    cyc(1'b1, 5'd9, 32'd500, 5'd9, 1'b1);
    @(posedge clk);
    #2;
    chk("ar_cnt500", rd_data, 32'd500);
    chk1("ar_int_pre", int_req, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_cnt0", rd_data, 32'd0);
    chk1("ar_int0", int_req, 1'b0);
    chk1("ar_take0", take, 1'b0);
    chk("ar_epc0", epc, 32'd0);
    @(negedge clk);
    apply(mk("", 1'b0, 5'd0, 32'd0, 5'd15, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0,
             32'd0, 1'b0, 1'b0, 32'd0, 1'b0));
    reset = 1'b0;
    #2;
    chk("ar_prid", rd_data, PRID_V);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
